// File: rtl/pipeline_scoreboard.sv
// Tracks in-flight register writes across DEPTH post-decode stages, raises the
// ID-stage stall and registers per-source forwarding selects for the EXE operand muxes.
module pipeline_scoreboard #(
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int REG_AW     = 4,
    parameter int LOAD_READY = 2,
    localparam int SELW      = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fwd_en,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic                      id_wb_en,
    input  logic                      id_is_load,
    input  logic [REG_AW-1:0]         id_dest,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    output logic                      stall,
    output logic [NUM_SRC*SELW-1:0]   exe_fwd_sel,
    output logic [DEPTH-1:0]          stage_valid
);

    logic [DEPTH-1:0]        ent_valid;
    logic [DEPTH-1:0]        ent_wb;
    logic [DEPTH-1:0]        ent_load;
    logic [REG_AW-1:0]       ent_dest [DEPTH];

    logic [NUM_SRC-1:0]      hit;
    logic [NUM_SRC-1:0]      hit_load;
    logic [NUM_SRC-1:0]      hit_early;
    int                      hit_k [NUM_SRC];
    logic [NUM_SRC-1:0]      src_stall;
    logic [NUM_SRC*SELW-1:0] sel_next;

    // Scan oldest to youngest so the lowest matching stage is left standing.
    always_comb begin
        hit       = '0;
        hit_load  = '0;
        hit_early = '0;
        src_stall = '0;
        sel_next  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            hit_k[i] = 0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (id_valid && id_src_used[i] && ent_valid[k] && ent_wb[k] &&
                    ent_dest[k] == id_src[i*REG_AW +: REG_AW]) begin
                    hit[i]      = 1'b1;
                    hit_load[i] = ent_load[k];
                    hit_k[i]    = k;
                    if (k <= DEPTH - 2) begin
                        hit_early[i] = 1'b1;
                    end
                end
            end
            if (fwd_en) begin
                src_stall[i] = hit[i] && hit_load[i] && (hit_k[i] < LOAD_READY - 1);
                if (hit[i] && !src_stall[i] && hit_k[i] < DEPTH - 1) begin
                    sel_next[i*SELW +: SELW] = SELW'(hit_k[i] + 1);
                end
            end else begin
                // WB write lands in the register file early enough for the ID read.
                src_stall[i] = hit_early[i];
            end
        end
    end

    assign stall       = (|src_stall) && !flush;
    assign stage_valid = ent_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid   <= '0;
            ent_wb      <= '0;
            ent_load    <= '0;
            exe_fwd_sel <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                ent_dest[k] <= '0;
            end
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_wb[k]    <= ent_wb[k-1];
                ent_load[k]  <= ent_load[k-1];
                ent_dest[k]  <= ent_dest[k-1];
            end
            if (flush || stall) begin
                ent_valid[0] <= 1'b0;
                ent_wb[0]    <= 1'b0;
                ent_load[0]  <= 1'b0;
                ent_dest[0]  <= '0;
                exe_fwd_sel  <= '0;
            end else begin
                ent_valid[0] <= id_valid;
                ent_wb[0]    <= id_wb_en;
                ent_load[0]  <= id_is_load;
                ent_dest[0]  <= id_dest;
                exe_fwd_sel  <= sel_next;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Directed bench for pipeline_scoreboard: default build (2 src, depth 3, load ready 2)
// and a wide build (3 src, depth 4, load ready 3) sharing one clock.
module tb_pipeline_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // default build
    logic       rst, fwd_en, flush, id_valid, id_wb_en, id_is_load;
    logic [3:0] id_dest;
    logic [7:0] id_src;
    logic [1:0] id_src_used;
    logic       stall;
    logic [3:0] exe_fwd_sel;
    logic [2:0] stage_valid;

    // wide build
    logic        rst4, fwd_en4, flush4, id_valid4, id_wb_en4, id_is_load4;
    logic [3:0]  id_dest4;
    logic [11:0] id_src4;
    logic [2:0]  id_src_used4;
    logic        stall4;
    logic [8:0]  exe_fwd_sel4;
    logic [3:0]  stage_valid4;

    pipeline_scoreboard u_dut (
        .clk(clk), .rst(rst), .fwd_en(fwd_en), .flush(flush),
        .id_valid(id_valid), .id_wb_en(id_wb_en), .id_is_load(id_is_load),
        .id_dest(id_dest), .id_src(id_src), .id_src_used(id_src_used),
        .stall(stall), .exe_fwd_sel(exe_fwd_sel), .stage_valid(stage_valid)
    );

    pipeline_scoreboard #(.NUM_SRC(3), .DEPTH(4), .REG_AW(4), .LOAD_READY(3)) u_dut4 (
        .clk(clk), .rst(rst4), .fwd_en(fwd_en4), .flush(flush4),
        .id_valid(id_valid4), .id_wb_en(id_wb_en4), .id_is_load(id_is_load4),
        .id_dest(id_dest4), .id_src(id_src4), .id_src_used(id_src_used4),
        .stall(stall4), .exe_fwd_sel(exe_fwd_sel4), .stage_valid(stage_valid4)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic wb, input logic ld, input logic [3:0] d,
                          input logic [3:0] s0, input logic [3:0] s1, input logic [1:0] used);
        id_valid    = v;
        id_wb_en    = wb;
        id_is_load  = ld;
        id_dest     = d;
        id_src      = {s1, s0};
        id_src_used = used;
        #1;
    endtask

    task automatic set_id4(input logic v, input logic wb, input logic ld, input logic [3:0] d,
                           input logic [3:0] s0, input logic [3:0] s2, input logic [2:0] used);
        id_valid4    = v;
        id_wb_en4    = wb;
        id_is_load4  = ld;
        id_dest4     = d;
        id_src4      = {s2, 4'd0, s0};
        id_src_used4 = used;
        #1;
    endtask

    task automatic drain(input int n);
        set_id(0, 0, 0, 0, 0, 0, 2'b00);
        for (int c = 0; c < n; c++) step();
    endtask

    initial begin
        rst = 1'b1; fwd_en = 1'b1; flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 2'b00);
        rst4 = 1'b1; fwd_en4 = 1'b1; flush4 = 1'b0;
        set_id4(0, 0, 0, 0, 0, 0, 3'b000);
        step(); step();
        rst = 1'b0; rst4 = 1'b0;
        step();

        check_val("rst_stall", 32'(stall), 32'd0);
        check_val("rst_stage_valid", 32'(stage_valid), 32'd0);
        check_val("rst_sel", 32'(exe_fwd_sel), 32'd0);
        check_val("rst_stage_valid4", 32'(stage_valid4), 32'd0);

        // ADD r1 ; SUB r2,r1,r3 with forwarding
        set_id(1, 1, 0, 4'd1, 4'd2, 4'd3, 2'b11);
        check_val("alu_add_stall", 32'(stall), 32'd0);
        step();
        set_id(1, 1, 0, 4'd2, 4'd1, 4'd3, 2'b11);
        check_val("alu_sub_stall", 32'(stall), 32'd0);
        step();
        set_id(0, 0, 0, 0, 0, 0, 2'b00);
        check_val("alu_sel", 32'(exe_fwd_sel), 32'h1);
        check_val("alu_stage_valid", 32'(stage_valid), 32'b011);
        drain(3);

        // LDR r4 ; ADD r5,r4,r4
        set_id(1, 1, 1, 4'd4, 4'd0, 4'd0, 2'b00);
        step();
        set_id(1, 1, 0, 4'd5, 4'd4, 4'd4, 2'b11);
        check_val("lu_stall_1st", 32'(stall), 32'd1);
        step();
        check_val("lu_bubble_sel", 32'(exe_fwd_sel), 32'd0);
        check_val("lu_bubble_valid", 32'(stage_valid), 32'b010);
        check_val("lu_stall_2nd", 32'(stall), 32'd0);
        step();
        set_id(0, 0, 0, 0, 0, 0, 2'b00);
        check_val("lu_sel", 32'(exe_fwd_sel), 32'hA);
        check_val("lu_stage_valid", 32'(stage_valid), 32'b101);
        drain(3);

        // Result already in WB with forwarding on: read the register file
        set_id(1, 1, 0, 4'd9, 4'd0, 4'd0, 2'b00);
        step();
        drain(2);
        set_id(1, 1, 0, 4'd10, 4'd0, 4'd9, 2'b10);
        check_val("wb_stall", 32'(stall), 32'd0);
        step();
        check_val("wb_sel", 32'(exe_fwd_sel), 32'd0);
        drain(3);

        // Forwarding disabled: ADD r1 ; ORR r2,r1,r1
        fwd_en = 1'b0;
        set_id(1, 1, 0, 4'd1, 4'd2, 4'd3, 2'b11);
        step();
        set_id(1, 1, 0, 4'd2, 4'd1, 4'd1, 2'b11);
        check_val("nofwd_stall_a", 32'(stall), 32'd1);
        step();
        check_val("nofwd_stall_b", 32'(stall), 32'd1);
        step();
        check_val("nofwd_stall_c", 32'(stall), 32'd0);
        step();
        set_id(0, 0, 0, 0, 0, 0, 2'b00);
        check_val("nofwd_sel", 32'(exe_fwd_sel), 32'd0);
        check_val("nofwd_stage_valid", 32'(stage_valid), 32'b001);
        drain(3);
        fwd_en = 1'b1;

        // MOV r6 twice, then reader: younger copy wins
        set_id(1, 1, 0, 4'd6, 4'd0, 4'd0, 2'b00);
        step();
        set_id(1, 1, 0, 4'd6, 4'd0, 4'd0, 2'b00);
        step();
        set_id(1, 1, 0, 4'd8, 4'd6, 4'd0, 2'b01);
        check_val("prio_stall", 32'(stall), 32'd0);
        step();
        set_id(0, 0, 0, 0, 0, 0, 2'b00);
        check_val("prio_sel", 32'(exe_fwd_sel), 32'h1);
        drain(3);

        // Same pattern, reader flushed
        set_id(1, 1, 0, 4'd6, 4'd0, 4'd0, 2'b00);
        step();
        set_id(1, 1, 0, 4'd6, 4'd0, 4'd0, 2'b00);
        step();
        set_id(1, 1, 0, 4'd8, 4'd6, 4'd0, 2'b01);
        flush = 1'b1;
        #1;
        check_val("flush_stall", 32'(stall), 32'd0);
        step();
        flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 2'b00);
        check_val("flush_sel", 32'(exe_fwd_sel), 32'd0);
        check_val("flush_stage_valid", 32'(stage_valid), 32'b110);
        drain(3);

        // Older ALU copy, younger non-ready load copy: load forces stall
        set_id(1, 1, 0, 4'd6, 4'd0, 4'd0, 2'b00);
        step();
        set_id(1, 1, 1, 4'd6, 4'd0, 4'd0, 2'b00);
        step();
        set_id(1, 1, 0, 4'd8, 4'd0, 4'd6, 2'b10);
        check_val("young_load_stall", 32'(stall), 32'd1);
        flush = 1'b1;
        #1;
        check_val("flush_over_stall", 32'(stall), 32'd0);
        step();
        flush = 1'b0;
        drain(3);

        // Wide build: LDR r7, reader of r7 on source 0
        set_id4(1, 1, 1, 4'd7, 4'd0, 4'd0, 3'b000);
        step();
        set_id4(1, 1, 0, 4'd1, 4'd7, 4'd0, 3'b001);
        check_val("w_stall_a", 32'(stall4), 32'd1);
        step();
        check_val("w_stall_b", 32'(stall4), 32'd1);
        step();
        check_val("w_stall_c", 32'(stall4), 32'd0);
        step();
        set_id4(0, 0, 0, 0, 0, 0, 3'b000);
        check_val("w_sel", 32'(exe_fwd_sel4), 32'h003);
        check_val("w_stage_valid", 32'(stage_valid4), 32'b1001);
        for (int c = 0; c < 4; c++) step();

        // Wide build: reset mid-stall, reader on source 2
        set_id4(1, 1, 1, 4'd7, 4'd0, 4'd0, 3'b000);
        step();
        set_id4(1, 1, 0, 4'd1, 4'd0, 4'd7, 3'b100);
        check_val("wr_stall", 32'(stall4), 32'd1);
        rst4 = 1'b1;
        step();
        rst4 = 1'b0;
        #1;
        check_val("wr_stage_valid", 32'(stage_valid4), 32'd0);
        check_val("wr_stall_after", 32'(stall4), 32'd0);
        step();
        check_val("wr_reader_in", 32'(stage_valid4), 32'b0001);
        check_val("wr_sel", 32'(exe_fwd_sel4), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
